pim_input_buffer: RTL and testbench
===================================

// Module: pim_input_buffer
// PURPOSE
//  Store-side counterpart of the PIM output path: gathers 32-bit words written by the RISC-V core into one
//  1024-bit input line for the eFlash PIM array. Ping-pong double buffer: CPU fills one bank while the other
//  is presented to the PIM controller over a valid/ready handshake. Word i maps to input_o[1023-32*i -: 32].
// PARAMETERS
//  WORDS   32  words per line (power of two)
//  WORD_W  32  bits per word; line width = WORDS*WORD_W
// PORTS
//  clk_i         in   1     clock
//  rst_ni        in   1     asynchronous active-low reset
//  store_en_i    in   1     CPU store strobe, one word per cycle
//  store_cnt_i   in   5     word index 0..31
//  store_data_i  in   32    store data
//  flush_i       in   1     commit partially filled write bank
//  store_ready_o out  1     1 = write bank can accept a store
//  in_valid_o    out  1     committed line presented to PIM
//  in_ready_i    in   1     PIM controller accepts line
//  input_o       out  1024  line data, stable while in_valid_o=1
//  overflow_o    out  1     sticky: store dropped while store_ready_o=0; cleared only by reset
//  zero_point_en_i in 1     (PIM_IN_ZERO_POINT_EN only) enable zero-point subtraction
//  zero_point_i  in   8     (PIM_IN_ZERO_POINT_EN only) per-byte zero point
// BEHAVIOUR
//  - Reset: both banks EMPTY, data/mask zero, wr_bank=0, rd_bank=0; store_ready_o=1, in_valid_o=0,
//    input_o='0, overflow_o=0. Reset mid-handshake discards both lines; no partial issue.
//  - Bank states: EMPTY -> FILLING (first store) -> FULL (mask all-ones, or flush_i) -> ISSUING (rd_bank
//    points at it) -> EMPTY (cycle after in_valid_o & in_ready_i). Per-bank 32-bit written mask.
//  - Store: accepted when store_en_i & store_ready_o; writes word, sets mask bit. A repeat index overwrites
//    the word with no mask change. A store completing the mask commits bank; wr_bank toggles next cycle.
//  - store_ready_o = 1 when bank[wr_bank] is EMPTY or FILLING; 0 when both banks are committed.
//  - Flush: on EMPTY write bank ignored. On FILLING bank it commits; unwritten words read as zero.
//    Store+flush same cycle: store applied first, then bank committed.
//  - Issue: oldest committed bank first (rd_bank). in_valid_o rises cycle N+1 after commit in cycle N if issue
//    side idle. input_o = bank[rd_bank] data. in_valid_o holds until in_ready_i; data must not change.
//    On handshake: bank cleared to EMPTY (data and mask zeroed), rd_bank toggles. Next committed bank,
//    if any, presented the following cycle (back-to-back lines: one idle cycle between valids is not allowed
//    when the other bank is already FULL; in_valid_o stays high, input_o switches).
//  - Handshake and store to the freed bank in the same cycle: store goes to current wr_bank only;
//    freed bank accepts stores from next cycle.
//  - in_ready_i while in_valid_o=0 is ignored.
// CONFIGURATION
//  PIM_IN_ZERO_POINT_EN defined: zero-point ports exist; when zero_point_en_i=1 every byte stored is
//    written as max(byte - zero_point_i, 0) (unsigned saturation), applied at store time.
//  Undefined: ports absent, data stored unmodified.
// STRUCTURE
//  Package pim_in_buf_pkg: WORDS, WORD_W, LINE_W constants; bank_state_e {EMPTY,FILLING,FULL,ISSUING};
//    word index typedef.
//  Sub-module pim_in_buf_bank: one bank (data regs, mask, state, write/commit/clear); top instantiates two
//    plus wr_bank/rd_bank pointers, store_ready_o/in_valid_o muxing and zero-point path.
// TESTING
//  1 Store words 0..31 with data=32'hA000_0000+i, in_ready_i=1 -> in_valid_o one cycle after 32nd store,
//    input_o[1023-:32]=A000_0000, input_o[31:0]=A000_001F; bank EMPTY after.
//  2 Store words 0..3 then flush_i -> line issued with words 4..31 = 0; flush on EMPTY -> no valid.
//  3 in_ready_i=0, fill two lines (64 stores) -> store_ready_o=0; 65th store dropped, overflow_o=1;
//    raise in_ready_i -> both lines issued back-to-back in order, in_valid_o held continuously.
//  4 Store index 5 twice (0x11 then 0x22) then fill rest -> word 5 = 0x22, commit after 32 unique indices.
//  5 Assert rst_ni low while in_valid_o=1 -> next cycle in_valid_o=0, input_o=0, store_ready_o=1.
//  6 PIM_IN_ZERO_POINT_EN, zp=8'h10, en=1, store 32'h05_20_10_FF -> word 32'h00_10_00_EF.

Source files
------------

// File: rtl/pim_in_buf_pkg.sv
// +-----------------------------------------------------------------------------+
// | pim_in_buf_pkg : shared constants and types for the PIM input line buffer   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

package pim_in_buf_pkg;

  localparam int WORDS  = 32;
  localparam int WORD_W = 32;
  localparam int LINE_W = WORDS * WORD_W;
  localparam int IDX_W  = $clog2(WORDS);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    ISSUING = 2'd3
  } bank_state_e;

  typedef logic [IDX_W-1:0] word_idx_t;

endpackage

`default_nettype wire

// File: rtl/pim_in_buf_bank.sv
// +-----------------------------------------------------------------------------+
// | pim_in_buf_bank : one line bank with written-word mask and life-cycle state  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pim_in_buf_bank
  import pim_in_buf_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [WORD_W-1:0]   wr_data_i,
  input  logic                flush_i,
  input  logic                issue_i,
  input  logic                clear_i,
  output logic                open_o,
  output logic                full_o,
  output logic                commit_o,
  output logic [LINE_W-1:0]   data_o
);

  bank_state_e       state_q, state_d;
  logic [WORDS-1:0]  mask_q, mask_d, mask_wr;
  logic [LINE_W-1:0] data_q, data_d;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    data_d   = data_q;
    commit_o = 1'b0;
    mask_wr  = mask_q;
    if (wr_en_i) begin
      mask_wr[wr_idx_i] = 1'b1;
    end

    case (state_q)
      EMPTY, FILLING: begin
        if (wr_en_i) begin
          mask_d  = mask_wr;
          state_d = FILLING;
          for (int w = 0; w < WORDS; w++) begin
            if (wr_idx_i == word_idx_t'(w)) begin
              data_d[LINE_W-1-WORD_W*w -: WORD_W] = wr_data_i;
            end
          end
        end
        // A same-cycle store counts toward the commit, so store+flush on EMPTY still commits.
        if ((wr_en_i && (&mask_wr)) ||
            (flush_i && (wr_en_i || (state_q == FILLING)))) begin
          commit_o = 1'b1;
          state_d  = FULL;
        end
      end
      FULL: begin
        if (clear_i) begin
          state_d = EMPTY;
          mask_d  = '0;
          data_d  = '0;
        end else if (issue_i) begin
          state_d = ISSUING;
        end
      end
      ISSUING: begin
        if (clear_i) begin
          state_d = EMPTY;
          mask_d  = '0;
          data_d  = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  assign open_o = (state_q == EMPTY) || (state_q == FILLING);
  assign full_o = (state_q == FULL) || (state_q == ISSUING);
  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/pim_input_buffer.sv
// +-----------------------------------------------------------------------------+
// | pim_input_buffer : ping-pong gatherer of CPU words into 1024-bit PIM lines   |
// | Optional feature macro: PIM_IN_ZERO_POINT_EN (per-byte zero-point subtract)  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pim_input_buffer
  import pim_in_buf_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                store_en_i,
  input  logic [4:0]          store_cnt_i,
  input  logic [31:0]         store_data_i,
  input  logic                flush_i,
  output logic                store_ready_o,
  output logic                in_valid_o,
  input  logic                in_ready_i,
  output logic [1023:0]       input_o,
  output logic                overflow_o
`ifdef PIM_IN_ZERO_POINT_EN
  ,
  input  logic                zero_point_en_i,
  input  logic [7:0]          zero_point_i
`endif
);

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              overflow_q, overflow_d;
  logic              store_acc, handshake;
  logic [1:0]        bank_open, bank_full, bank_commit;
  logic [1:0]        bank_wr_en, bank_flush, bank_issue, bank_clear;
  logic [LINE_W-1:0] bank_data [2];
  logic [WORD_W-1:0] store_word;

`ifdef PIM_IN_ZERO_POINT_EN
  // Unsigned saturating subtract, byte by byte, applied before the word is written.
  for (genvar b = 0; b < WORD_W / 8; b++) begin : g_zp_byte
    logic [7:0] byte_in;
    assign byte_in = store_data_i[8*b +: 8];
    assign store_word[8*b +: 8] =
      (zero_point_en_i && (byte_in <= zero_point_i)) ? 8'h00 :
      (zero_point_en_i ? (byte_in - zero_point_i) : byte_in);
  end
`else
  assign store_word = store_data_i;
`endif

  always_comb begin
    store_ready_o = bank_open[wr_bank_q];
    in_valid_o    = bank_full[rd_bank_q];
    store_acc     = store_en_i & store_ready_o;
    handshake     = in_valid_o & in_ready_i;
    wr_bank_d     = wr_bank_q ^ bank_commit[wr_bank_q];
    rd_bank_d     = rd_bank_q ^ handshake;
    overflow_d    = overflow_q | (store_en_i & ~store_ready_o);
    input_o       = in_valid_o ? bank_data[rd_bank_q] : '0;
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign bank_wr_en[g] = store_acc & (wr_bank_q == 1'(g));
    assign bank_flush[g] = flush_i   & (wr_bank_q == 1'(g));
    assign bank_issue[g] = (rd_bank_q == 1'(g));
    assign bank_clear[g] = handshake & (rd_bank_q == 1'(g));

    pim_in_buf_bank u_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (bank_wr_en[g]),
      .wr_idx_i  (store_cnt_i),
      .wr_data_i (store_word),
      .flush_i   (bank_flush[g]),
      .issue_i   (bank_issue[g]),
      .clear_i   (bank_clear[g]),
      .open_o    (bank_open[g]),
      .full_o    (bank_full[g]),
      .commit_o  (bank_commit[g]),
      .data_o    (bank_data[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_pim_input_buffer.sv
// +-----------------------------------------------------------------------------+
// | tb_pim_input_buffer : directed self-checking bench for pim_input_buffer      |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_pim_input_buffer;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          store_en_i;
  logic [4:0]    store_cnt_i;
  logic [31:0]   store_data_i;
  logic          flush_i;
  logic          store_ready_o;
  logic          in_valid_o;
  logic          in_ready_i;
  logic [1023:0] input_o;
  logic          overflow_o;
`ifdef PIM_IN_ZERO_POINT_EN
  logic          zero_point_en_i;
  logic [7:0]    zero_point_i;
`endif

  int checks = 0;
  int errors = 0;
  logic [1023:0] exp_line;
  logic [1023:0] exp_line2;

  always #5 clk = ~clk;

  pim_input_buffer dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .store_en_i    (store_en_i),
    .store_cnt_i   (store_cnt_i),
    .store_data_i  (store_data_i),
    .flush_i       (flush_i),
    .store_ready_o (store_ready_o),
    .in_valid_o    (in_valid_o),
    .in_ready_i    (in_ready_i),
    .input_o       (input_o),
    .overflow_o    (overflow_o)
`ifdef PIM_IN_ZERO_POINT_EN
    ,
    .zero_point_en_i (zero_point_en_i),
    .zero_point_i    (zero_point_i)
`endif
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int bad;
    checks++;
    assert (obs === exp) else begin
      errors++;
      bad = 0;
      for (int w = 31; w >= 0; w--) begin
        if (obs[1023-32*w -: 32] !== exp[1023-32*w -: 32]) bad = w;
      end
      $error("FAIL %s word%0d observed=%h expected=%h", tag, bad,
             obs[1023-32*bad -: 32], exp[1023-32*bad -: 32]);
    end
  endtask

  task automatic do_store(input int idx, input logic [31:0] d);
    store_en_i   = 1'b1;
    store_cnt_i  = 5'(idx);
    store_data_i = d;
    @(negedge clk);
    store_en_i   = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    store_en_i   = 1'b0;
    store_cnt_i  = '0;
    store_data_i = '0;
    flush_i      = 1'b0;
    in_ready_i   = 1'b0;
`ifdef PIM_IN_ZERO_POINT_EN
    zero_point_en_i = 1'b0;
    zero_point_i    = 8'h00;
`endif
    @(negedge clk);
    @(negedge clk);
    check_bit("reset_store_ready", store_ready_o, 1'b1);
    check_bit("reset_in_valid", in_valid_o, 1'b0);
    check_line("reset_input", input_o, '0);
    check_bit("reset_overflow", overflow_o, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk);

    // Full line, consumer ready.
    in_ready_i = 1'b1;
    exp_line = '0;
    for (int i = 0; i < 32; i++) begin
      exp_line[1023-32*i -: 32] = 32'hA000_0000 + 32'(i);
      do_store(i, 32'hA000_0000 + 32'(i));
    end
    check_bit("t1_valid", in_valid_o, 1'b1);
    check_word("t1_word0", input_o[1023 -: 32], 32'hA000_0000);
    check_word("t1_word31", input_o[31:0], 32'hA000_001F);
    check_line("t1_line", input_o, exp_line);
    check_bit("t1_store_ready", store_ready_o, 1'b1);
    @(negedge clk);
    check_bit("t1_valid_drop", in_valid_o, 1'b0);
    check_line("t1_input_clear", input_o, '0);

    // Partial line committed by flush.
    exp_line = '0;
    for (int i = 0; i < 4; i++) begin
      exp_line[1023-32*i -: 32] = 32'h0000_0100 + 32'(i);
      do_store(i, 32'h0000_0100 + 32'(i));
    end
    check_bit("t2_no_valid_before_flush", in_valid_o, 1'b0);
    do_flush();
    check_bit("t2_valid", in_valid_o, 1'b1);
    check_line("t2_line", input_o, exp_line);
    @(negedge clk);
    check_bit("t2_valid_drop", in_valid_o, 1'b0);
    do_flush();
    check_bit("t2_empty_flush", in_valid_o, 1'b0);
    @(negedge clk);
    check_bit("t2_empty_flush_late", in_valid_o, 1'b0);

    // Two lines with consumer stalled, then overflow, then back-to-back issue.
    in_ready_i = 1'b0;
    exp_line  = '0;
    exp_line2 = '0;
    for (int i = 0; i < 32; i++) begin
      exp_line[1023-32*i -: 32] = 32'hB000_0000 + 32'(i);
      do_store(i, 32'hB000_0000 + 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      exp_line2[1023-32*i -: 32] = 32'hC000_0000 + 32'(i);
      do_store(i, 32'hC000_0000 + 32'(i));
    end
    check_bit("t3_store_ready_low", store_ready_o, 1'b0);
    check_bit("t3_valid", in_valid_o, 1'b1);
    check_line("t3_first_line", input_o, exp_line);
    check_bit("t3_no_overflow_yet", overflow_o, 1'b0);
    do_store(0, 32'hDEAD_BEEF);
    check_bit("t3_overflow", overflow_o, 1'b1);
    check_line("t3_first_line_stable", input_o, exp_line);
    in_ready_i = 1'b1;
    @(negedge clk);
    check_bit("t3_valid_held", in_valid_o, 1'b1);
    check_line("t3_second_line", input_o, exp_line2);
    @(negedge clk);
    check_bit("t3_valid_drop", in_valid_o, 1'b0);
    check_bit("t3_store_ready_back", store_ready_o, 1'b1);
    check_bit("t3_overflow_sticky", overflow_o, 1'b1);

    // Repeated index overwrites without advancing the mask.
    in_ready_i = 1'b0;
    exp_line = '0;
    do_store(5, 32'h0000_0011);
    do_store(5, 32'h0000_0022);
    exp_line[1023-32*5 -: 32] = 32'h0000_0022;
    check_bit("t4_no_commit_on_repeat", in_valid_o, 1'b0);
    for (int i = 0; i < 31; i++) begin
      if (i != 5) begin
        exp_line[1023-32*i -: 32] = 32'h0000_0400 + 32'(i);
        do_store(i, 32'h0000_0400 + 32'(i));
      end
    end
    check_bit("t4_not_full_31_unique", in_valid_o, 1'b0);
    exp_line[31:0] = 32'h0000_041F;
    do_store(31, 32'h0000_041F);
    check_bit("t4_valid", in_valid_o, 1'b1);
    check_word("t4_word5", input_o[1023-32*5 -: 32], 32'h0000_0022);
    check_line("t4_line", input_o, exp_line);

    // Reset while a line is presented.
    rst_ni = 1'b0;
    @(negedge clk);
    check_bit("t5_valid_cleared", in_valid_o, 1'b0);
    check_line("t5_input_cleared", input_o, '0);
    check_bit("t5_store_ready", store_ready_o, 1'b1);
    check_bit("t5_overflow_cleared", overflow_o, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk);

`ifdef PIM_IN_ZERO_POINT_EN
    in_ready_i      = 1'b1;
    zero_point_en_i = 1'b1;
    zero_point_i    = 8'h10;
    do_store(0, 32'h0520_10FF);
    zero_point_en_i = 1'b0;
    do_flush();
    check_bit("t6_valid", in_valid_o, 1'b1);
    check_word("t6_word0", input_o[1023 -: 32], 32'h0010_00EF);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
